// File: rtl/mul_job_ctrl_if.sv
// Handshake and multiplier-core signal bundle for mul_job_ctrl.
// slave is the sequencer's view; master is the producer/consumer/core side.
interface mul_job_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_load;
  logic        mul_wait;
  logic        mul_ready;
  logic [31:0] mul_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;
  logic        busy;

  modport slave (
    input  in_valid, in_a, in_b, mul_wait, mul_ready, mul_result, out_ready,
    output in_ready, mul_a, mul_b, mul_load, out_valid, out_result, out_err, busy
  );

  modport master (
    output in_valid, in_a, in_b, mul_wait, mul_ready, mul_result, out_ready,
    input  in_ready, mul_a, mul_b, mul_load, out_valid, out_result, out_err, busy
  );
endinterface

// File: rtl/mul_job_ctrl.sv
// Operand FIFO + one-job-at-a-time sequencer around the shift-and-add multiplier; result in t+3+k (bypass/error t+2).
// IN_READY drops when the FIFO is full; OUT_RESULT/OUT_ERR hold until OUT_READY.
module mul_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_dat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[rd_q[AW-1:0]];
  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

module mul_job_ctrl #(
  parameter int DEPTH    = 4,
  parameter int WD_LIMIT = 17
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mul_job_ctrl_if.slave      job_if
);
  localparam int WW = $clog2(WD_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, OUT} state_t;

  state_t        state_q, state_d;
  logic [15:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   res_q, res_d;
  logic          err_q, err_d;
  logic [WW-1:0] wd_q, wd_d;

  logic          push, pop, full, empty, launch_ok;
  logic [31:0]   head;
  logic [15:0]   head_lo, head_hi;

  assign push = job_if.in_valid & ~full;

  mul_job_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_dat_i ({job_if.in_a, job_if.in_b}),
    .pop_i      (pop),
    .pop_dat_o  (head),
    .full_o     (full),
    .empty_o    (empty)
  );

  // Smaller operand goes to B: B path is limited to 15 bits and its MSB sets the iteration count.
  assign head_lo = (head[31:16] < head[15:0]) ? head[31:16] : head[15:0];
  assign head_hi = (head[31:16] < head[15:0]) ? head[15:0]  : head[31:16];

  // Operands are classified from the registered copy, so zero/range jobs spend
  // their LAUNCH cycle with MUL_LOAD held low.
  assign launch_ok = (b_q != 16'h0000) && !b_q[15];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    wd_d    = wd_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          a_d     = head_hi;
          b_d     = head_lo;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (launch_ok) begin
          wd_d    = '0;
          state_d = RUN;
        end else begin
          res_d   = '0;
          err_d   = b_q[15];
          state_d = OUT;
        end
      end
      RUN: begin
        // A stalled core (MUL_WAIT low, no MUL_READY) is only ended by the watchdog.
        if (job_if.mul_ready) begin
          res_d   = job_if.mul_result;
          err_d   = 1'b0;
          state_d = OUT;
        end else if (wd_q == WW'(WD_LIMIT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = OUT;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      OUT: begin
        if (job_if.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign job_if.in_ready   = ~full;
  assign job_if.mul_a      = a_q;
  assign job_if.mul_b      = b_q;
  assign job_if.mul_load   = ((state_q == LAUNCH) && launch_ok) || (state_q == RUN);
  assign job_if.out_valid  = (state_q == OUT);
  assign job_if.out_result = res_q;
  assign job_if.out_err    = err_q;
  assign job_if.busy       = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_mul_job_ctrl.sv
`timescale 1ns/1ps
module tb_mul_job_ctrl;
  localparam int DEPTH    = 4;
  localparam int WD_LIMIT = 17;
  localparam int NRAND    = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   hang_mode = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mcnt;

  logic [31:0] exp_r[$];
  logic        exp_e[$];

  mul_job_ctrl_if bus();

  mul_job_ctrl #(.DEPTH(DEPTH), .WD_LIMIT(WD_LIMIT)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .job_if (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int msb_idx(input logic [15:0] v);
    int k = 0;
    for (int i = 0; i < 16; i++) if (v[i]) k = i;
    return k;
  endfunction

  // Job outcome from the arithmetic rules alone.
  function automatic void ref_job(input logic [15:0] a, input logic [15:0] b,
                                  output logic [31:0] r, output logic e);
    logic [15:0] lo;
    lo = (a < b) ? a : b;
    if (lo == 16'h0)          begin r = 32'h0; e = 1'b0; end
    else if (lo >= 16'h8000)  begin r = 32'h0; e = 1'b1; end
    else                      begin r = {16'h0, a} * {16'h0, b}; e = 1'b0; end
  endfunction

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'($urandom_range(32'h8000, 32'hFFFF));
      2:       return 16'($urandom_range(1, 15));
      default: return 16'($urandom_range(1, 32'hFFFF));
    endcase
  endfunction

  // Core model: finishes MSB(B)+1 edges after the load enable is first sampled.
  always @(posedge clk or posedge rst) begin
    if (rst)               mcnt <= 0;
    else if (bus.mul_load) mcnt <= mcnt + 1;
    else                   mcnt <= 0;
  end

  always_comb begin
    bus.mul_ready  = !hang_mode && (mcnt != 0) && (mcnt == msb_idx(bus.mul_b) + 1);
    bus.mul_wait   = (mcnt != 0) && !hang_mode && !bus.mul_ready;
    bus.mul_result = bus.mul_ready ? ({16'h0, bus.mul_a} * {16'h0, bus.mul_b}) : 32'hDEAD_BEEF;
  end

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mul_load, bus.mul_a, bus.mul_b, bus.out_valid, bus.out_result, bus.out_err, bus.busy} !== 68'h0) begin
      n_err++;
      $display("FAIL reset_async: load=%b a=%h b=%h ov=%b res=%h err=%b busy=%b, all must be 0",
               bus.mul_load, bus.mul_a, bus.mul_b, bus.out_valid, bus.out_result, bus.out_err, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    n_cmp++;
    if ({bus.mul_load, bus.out_valid, bus.out_err, bus.busy, bus.out_result} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_idle: load=%b ov=%b err=%b busy=%b res=%h want all 0",
               bus.mul_load, bus.out_valid, bus.out_err, bus.busy, bus.out_result);
    end
  endtask

  task automatic run_job(input string name, input logic [15:0] a, input logic [15:0] b, input bit hang);
    logic [31:0] er;
    logic        ee;
    logic [15:0] lo, hi, sa, sb;
    int          elat, eload, n, loads;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    ref_job(a, b, er, ee);
    if (lo == 16'h0 || lo >= 16'h8000) begin elat = 2; eload = 0; end
    else if (hang) begin elat = 2 + WD_LIMIT; eload = 1 + WD_LIMIT; er = 32'h0; ee = 1'b1; end
    else begin elat = 3 + msb_idx(lo); eload = 2 + msb_idx(lo); end
    hang_mode     = hang;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0; loads = 0; sa = 16'h0; sb = 16'h0;
    while (n < 100) begin
      @(negedge clk);
      if (bus.mul_load) begin loads++; sa = bus.mul_a; sb = bus.mul_b; end
      if (bus.out_valid) break;
      n++;
    end
    n_cmp++;
    if (n !== elat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", name, n, elat); end
    n_cmp++;
    if (bus.out_result !== er || bus.out_err !== ee) begin
      n_err++; $display("FAIL %s result: got %h/err %b want %h/err %b", name, bus.out_result, bus.out_err, er, ee);
    end
    n_cmp++;
    if (loads !== eload) begin n_err++; $display("FAIL %s load_cycles: got %0d want %0d", name, loads, eload); end
    if (eload > 0) begin
      n_cmp++;
      if (sa !== hi || sb !== lo) begin
        n_err++; $display("FAIL %s operands: got A=%h B=%h want A=%h B=%h", name, sa, sb, hi, lo);
      end
    end
    @(posedge clk);
    #1 hang_mode = 1'b0;
  endtask

  task automatic test_random();
    int sent = 0;
    int got  = 0;
    exp_r.delete(); exp_e.delete();
    fork
      begin : drv
        int dcyc = 0;
        logic [15:0] a, b;
        logic [31:0] r;
        logic e;
        while (sent < NRAND && dcyc < 4000) begin
          @(negedge clk); dcyc++;
          if ($urandom_range(0, 2) != 0) begin
            a = rnd_op(); b = rnd_op();
            bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
            if (bus.in_ready) begin
              ref_job(a, b, r, e);
              exp_r.push_back(r); exp_e.push_back(e); sent++;
            end
          end else begin
            bus.in_valid = 1'b0;
          end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      begin : mon
        int          mcyc = 0;
        bit          stall = 1'b0;
        logic [31:0] pr, er;
        logic        pe, ee;
        while (got < NRAND && mcyc < 4000) begin
          @(negedge clk); mcyc++;
          if (stall) begin
            n_cmp++;
            if ({bus.out_valid, bus.out_err, bus.out_result} !== {1'b1, pe, pr}) begin
              n_err++;
              $display("FAIL rand_hold: got v=%b err=%b res=%h want v=1 err=%b res=%h",
                       bus.out_valid, bus.out_err, bus.out_result, pe, pr);
            end
          end
          bus.out_ready = ($urandom_range(0, 3) != 0);
          if (bus.out_valid) begin
            if (bus.out_ready) begin
              er = (exp_r.size() > 0) ? exp_r.pop_front() : 32'hxxxx_xxxx;
              ee = (exp_e.size() > 0) ? exp_e.pop_front() : 1'bx;
              n_cmp++;
              if (bus.out_result !== er || bus.out_err !== ee) begin
                n_err++;
                $display("FAIL rand_job%0d: got %h/err %b want %h/err %b", got, bus.out_result, bus.out_err, er, ee);
              end
              got++;
            end
            stall = !bus.out_ready; pr = bus.out_result; pe = bus.out_err;
          end else begin
            stall = 1'b0;
          end
        end
      end
    join
    n_cmp++;
    if (got !== NRAND) begin n_err++; $display("FAIL rand_count: got %0d outputs want %0d", got, NRAND); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [15:0] pa[6], pb[6];
    logic [31:0] er;
    logic        ee;
    int          acc = 0;
    int          got = 0;
    int          cyc = 0;
    for (int i = 0; i < 6; i++) begin pa[i] = 16'(100 + i * 37); pb[i] = 16'(7 + i * 5); end
    bus.out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (acc < 6) begin
        bus.in_valid = 1'b1; bus.in_a = pa[acc]; bus.in_b = pb[acc];
        if (bus.in_ready) acc++;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    n_cmp++;
    if (acc !== 1 + DEPTH) begin n_err++; $display("FAIL bp_accepted: got %0d want %0d", acc, 1 + DEPTH); end
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL bp_full: in_ready=%b ov=%b busy=%b want 0/1/1", bus.in_ready, bus.out_valid, bus.busy);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (got < acc && cyc < 300) begin
      if (bus.out_valid) begin
        ref_job(pa[got], pb[got], er, ee);
        n_cmp++;
        if (bus.out_result !== er || bus.out_err !== ee) begin
          n_err++; $display("FAIL bp_out%0d: got %h/err %b want %h/err %b", got, bus.out_result, bus.out_err, er, ee);
        end
        got++;
      end
      @(negedge clk); cyc++;
    end
    n_cmp++;
    if (got !== acc) begin n_err++; $display("FAIL bp_drain: got %0d outputs want %0d", got, acc); end

    // Long job, then reset while the core is still iterating.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = 16'hFFFF; bus.in_b = 16'h4000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.mul_load !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL midrun_state: load=%b ov=%b want 1/0", bus.mul_load, bus.out_valid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mul_load, bus.mul_a, bus.mul_b, bus.out_valid, bus.out_result, bus.out_err, bus.busy} !== 68'h0) begin
      n_err++;
      $display("FAIL midrun_reset: load=%b a=%h b=%h ov=%b res=%h err=%b busy=%b, all must be 0",
               bus.mul_load, bus.mul_a, bus.mul_b, bus.out_valid, bus.out_result, bus.out_err, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.out_valid || bus.mul_load || bus.busy) cyc++;
    end
    n_cmp++;
    if (cyc !== 0) begin n_err++; $display("FAIL post_reset_quiet: got %0d active cycles want 0", cyc); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = 16'h0;
    bus.in_b      = 16'h0;
    bus.out_ready = 1'b0;
    test_reset();
    run_job("mul5x3",      16'd5,    16'd3,    1'b0);
    run_job("max_product", 16'hFFFF, 16'h7FFF, 1'b0);
    run_job("bypass_zero", 16'h1234, 16'h0000, 1'b0);
    run_job("range_err",   16'h8001, 16'h8001, 1'b0);
    run_job("after_err",   16'd2,    16'd2,    1'b0);
    run_job("swap",        16'd3,    16'd5000, 1'b0);
    run_job("b_is_one",    16'hABCD, 16'd1,    1'b0);
    run_job("watchdog",    16'd9,    16'd3,    1'b1);
    run_job("after_wd",    16'd6,    16'd7,    1'b0);
    test_random();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
